// File: rtl/clk_div_pkg.sv
// Shared types for the multi-channel clock divider bank.
// Per-channel control bundle travels from the bank to each channel.
package clk_div_pkg;

   localparam int CNT_W = 21;

   typedef logic [CNT_W-1:0] div_t;

   typedef enum logic {
      MODE_TOGGLE = 1'b0,
      MODE_PULSE  = 1'b1
   } mode_e;

   typedef struct packed {
      logic  en;
      mode_e mode;
      logic  wr;
      logic  sync;
   } chan_ctl_t;

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: down-counter, shadowed divisor,
// divided clock level and terminal-count tick.
module clk_div_chan
   import clk_div_pkg::*;
#(
   parameter int W       = clk_div_pkg::CNT_W,
   parameter int DIV_RST = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  chan_ctl_t    ctl,
   input  logic [W-1:0] div,
   output logic         clk_o,
   output logic         tick_o,
   output logic         pend_o
);

   localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};
   localparam logic [W-1:0] RST_DIV = W'(DIV_RST);

   logic [W-1:0] cnt;
   logic [W-1:0] act;
   logic [W-1:0] shd;
   logic [W-1:0] wr_val;
   logic [W-1:0] nxt_div;
   logic         tc;
   logic         hold;

   assign wr_val  = (div == '0) ? ONE : div;
   assign nxt_div = pend_o ? shd : act;
   assign tc      = (cnt == '0);
   assign hold    = ctl.sync | ~ctl.en;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt    <= '0;
         act    <= RST_DIV;
         shd    <= RST_DIV;
         pend_o <= 1'b0;
         clk_o  <= 1'b0;
         tick_o <= 1'b0;
      end else begin
         if (hold) begin
            // idle: park at terminal count so the next
            // enabled cycle ticks immediately
            cnt    <= '0;
            clk_o  <= 1'b0;
            tick_o <= 1'b0;
            if (pend_o) act <= shd;
            pend_o <= 1'b0;
         end else if (tc) begin
            cnt    <= nxt_div - ONE;
            tick_o <= 1'b1;
            if (pend_o) act <= shd;
            pend_o <= 1'b0;
            if (ctl.mode == MODE_PULSE) clk_o <= 1'b1;
            else                        clk_o <= ~clk_o;
         end else begin
            cnt    <= cnt - ONE;
            tick_o <= 1'b0;
            if (ctl.mode == MODE_PULSE) clk_o <= 1'b0;
         end
         // a write lands after any reload so it waits a period
         if (ctl.wr) begin
            shd    <= wr_val;
            pend_o <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/clk_div_bank.sv
// Bank of N_CH programmable dividers sharing one clock
// and a common phase-align strobe.
module clk_div_bank #(
   parameter int N_CH    = 4,
   parameter int CNT_W   = clk_div_pkg::CNT_W,
   parameter int DIV_RST = 1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [N_CH-1:0]            en_i,
   input  logic [N_CH-1:0]            mode_i,
   input  logic [N_CH-1:0][CNT_W-1:0] div_i,
   input  logic [N_CH-1:0]            div_wr_i,
   input  logic                       sync_i,
   output logic [N_CH-1:0]            clk_o,
   output logic [N_CH-1:0]            tick_o,
   output logic [N_CH-1:0]            pend_o
);

   import clk_div_pkg::*;

   for (genvar c = 0; c < N_CH; c++) begin : g_ch
      chan_ctl_t ctl;

      assign ctl.en   = en_i[c];
      assign ctl.mode = mode_e'(mode_i[c]);
      assign ctl.wr   = div_wr_i[c];
      assign ctl.sync = sync_i;

      clk_div_chan #(
         .W       (CNT_W),
         .DIV_RST (DIV_RST)
      ) u_chan (
         .clk    (clk),
         .reset  (reset),
         .ctl    (ctl),
         .div    (div_i[c]),
         .clk_o  (clk_o[c]),
         .tick_o (tick_o[c]),
         .pend_o (pend_o[c])
      );
   end

endmodule

// File: tb/tb_clk_div_bank.sv
// Directed bench for clk_div_bank.
// Expected patterns are hand-derived cycle by cycle.
module tb_clk_div_bank;

   localparam int N_CH    = 4;
   localparam int CNT_W   = 21;
   localparam int DIV_RST = 1;

   logic                       clk = 1'b0;
   logic                       reset;
   logic [N_CH-1:0]            en_i;
   logic [N_CH-1:0]            mode_i;
   logic [N_CH-1:0][CNT_W-1:0] div_i;
   logic [N_CH-1:0]            div_wr_i;
   logic                       sync_i;
   logic [N_CH-1:0]            clk_o;
   logic [N_CH-1:0]            tick_o;
   logic [N_CH-1:0]            pend_o;

   int n_chk = 0;
   int n_err = 0;
   logic [31:0] tp;
   logic [31:0] cp;

   clk_div_bank #(
      .N_CH    (N_CH),
      .CNT_W   (CNT_W),
      .DIV_RST (DIV_RST)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .en_i     (en_i),
      .mode_i   (mode_i),
      .div_i    (div_i),
      .div_wr_i (div_wr_i),
      .sync_i   (sync_i),
      .clk_o    (clk_o),
      .tick_o   (tick_o),
      .pend_o   (pend_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input int unsigned got,
                        input int unsigned exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h",
                  tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input int ch, input int unsigned v);
      div_i[ch]    = v[CNT_W-1:0];
      div_wr_i[ch] = 1'b1;
      cyc();
      div_wr_i[ch] = 1'b0;
   endtask

   task automatic run_cap(input int ch, input int n);
      tp = '0;
      cp = '0;
      for (int k = 0; k < n; k++) begin
         cyc();
         tp[k] = tick_o[ch];
         cp[k] = clk_o[ch];
      end
   endtask

   initial begin
      reset    = 1'b0;
      en_i     = '0;
      mode_i   = '0;
      div_i    = '0;
      div_wr_i = '0;
      sync_i   = 1'b0;
      #1;
      check("rst_clk", 32'(clk_o), 0);
      check("rst_tick", 32'(tick_o), 0);
      check("rst_pend", 32'(pend_o), 0);
      repeat (2) @(posedge clk);
      #3 reset = 1'b1;
      cyc();

      // toggle mode, divisor 3
      wr(0, 3);
      check("t1_pend_set", 32'(pend_o[0]), 1);
      cyc();
      check("t1_pend_clr", 32'(pend_o[0]), 0);
      en_i[0] = 1'b1;
      run_cap(0, 12);
      check("t1_tick", tp, 32'h249);
      check("t1_clk", cp, 32'h1C7);
      en_i[0] = 1'b0;
      cyc();
      check("t1_off", 32'({clk_o[0], tick_o[0]}), 0);

      // pulse mode, divisor 1
      mode_i[1] = 1'b1;
      wr(1, 1);
      cyc();
      en_i[1] = 1'b1;
      run_cap(1, 6);
      check("t2_tick", tp, 32'h3F);
      check("t2_clk", cp, 32'h3F);
      en_i[1] = 1'b0;
      cyc();
      check("t2_off", 32'({clk_o[1], tick_o[1]}), 0);

      // div 4 running, write 5 mid-period
      mode_i[2] = 1'b1;
      wr(2, 4);
      cyc();
      en_i[2] = 1'b1;
      tp = '0;
      for (int k = 0; k < 15; k++) begin
         cyc();
         tp[k] = tick_o[2];
         if (k == 1) begin
            div_i[2]    = 21'd5;
            div_wr_i[2] = 1'b1;
         end
         if (k == 2) begin
            div_wr_i[2] = 1'b0;
            check("t3_pend_set", 32'(pend_o[2]), 1);
         end
         if (k == 4)
            check("t3_pend_clr", 32'(pend_o[2]), 0);
      end
      check("t3_tick", tp, 32'h4211);

      // write 7 on the terminal count while 6 is pending
      en_i[2] = 1'b0;
      cyc();
      en_i[2] = 1'b1;
      tp = '0;
      for (int k = 0; k < 19; k++) begin
         cyc();
         tp[k] = tick_o[2];
         if (k == 1) begin
            div_i[2]    = 21'd6;
            div_wr_i[2] = 1'b1;
         end
         if (k == 2) div_wr_i[2] = 1'b0;
         if (k == 4) begin
            div_i[2]    = 21'd7;
            div_wr_i[2] = 1'b1;
         end
         if (k == 5) begin
            div_wr_i[2] = 1'b0;
            check("t4_pend_hold", 32'(pend_o[2]), 1);
         end
         if (k == 11)
            check("t4_pend_clr", 32'(pend_o[2]), 0);
      end
      check("t4_tick", tp, 32'h40821);

      // sync aligns channels with divisors 2/3/4/5
      en_i = '0;
      mode_i = '0;
      cyc();
      div_i[0] = 21'd2;
      div_i[1] = 21'd3;
      div_i[2] = 21'd4;
      div_i[3] = 21'd5;
      div_wr_i = '1;
      cyc();
      div_wr_i = '0;
      cyc();
      en_i = '1;
      repeat (7) cyc();
      sync_i = 1'b1;
      cyc();
      check("t5_sync_tick", 32'(tick_o), 0);
      check("t5_sync_clk", 32'(clk_o), 0);
      sync_i = 1'b0;
      cyc();
      check("t5_aligned", 32'(tick_o), 32'hF);
      cyc();
      check("t5_after1", 32'(tick_o), 0);
      cyc();
      check("t5_after2", 32'(tick_o), 32'h1);

      // divisor 0 behaves as 1
      en_i = '0;
      cyc();
      mode_i[3] = 1'b1;
      wr(3, 0);
      cyc();
      en_i[3] = 1'b1;
      run_cap(3, 4);
      check("t6_zero_tick", tp, 32'hF);
      check("t6_zero_clk", cp, 32'hF);

      // asynchronous reset mid-count
      en_i = '0;
      mode_i = '0;
      cyc();
      wr(0, 5);
      cyc();
      en_i[0] = 1'b1;
      repeat (2) cyc();
      div_i[0]    = 21'd9;
      div_wr_i[0] = 1'b1;
      cyc();
      div_wr_i[0] = 1'b0;
      check("t6_pre_pend", 32'(pend_o[0]), 1);
      check("t6_pre_clk", 32'(clk_o[0]), 1);
      #2 reset = 1'b0;
      #1;
      check("t6_rst_clk", 32'(clk_o), 0);
      check("t6_rst_tick", 32'(tick_o), 0);
      check("t6_rst_pend", 32'(pend_o), 0);
      #2 reset = 1'b1;
      run_cap(0, 4);
      check("t6_post_tick", tp, 32'hF);
      check("t6_post_clk", cp, 32'h5);

      $display("Simulation finished: %0d checks, %0d errors",
               n_chk, n_err);
      $finish;
   end

endmodule
